// File: rtl/uart_pkg.sv
// Shared types for the configurable UART: frame FSM states, latched frame
// configuration and data-length encodings.
package uart_pkg;

  localparam int UART_DIV_W = 16;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  typedef struct packed {
    logic [UART_DIV_W-1:0] clks_per_bit;
    logic [1:0]            data_bits;
    logic                  parity_en;
    logic                  parity_odd;
    logic                  stop2;
  } uart_cfg_t;

  // Index of the last transmitted data bit for a data-length encoding.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
    case (data_bits)
      DATA_BITS_5: return 3'd4;
      DATA_BITS_6: return 3'd5;
      DATA_BITS_7: return 3'd6;
      DATA_BITS_8: return 3'd7;
      default:     return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte push handshake into the UART transmit FIFO (valid/ready).
interface uart_tx_cfg_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an occupancy count;
// the head entry is visible on pop_data whenever the FIFO is not empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg, level_next;
  logic             full_reg, empty_reg;
  logic             do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  always_comb begin
    level_next = level_reg;
    if (do_push && !do_pop) begin
      level_next = level_reg + 1'b1;
    end else if (!do_push && do_pop) begin
      level_next = level_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      full_reg  <= (level_next == LW'(DEPTH));
      empty_reg <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, optional parity, 1/2 stop
// bits, runtime divisor, fed from a transmit FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  uart_tx_cfg_if.slave                  push,
  input  logic [DIV_W-1:0]              cfg_clks_per_bit_i,
  input  logic [1:0]                    cfg_data_bits_i,
  input  logic                          cfg_parity_en_i,
  input  logic                          cfg_parity_odd_i,
  input  logic                          cfg_stop2_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  uart_tx_state_e   state_reg, state_next;
  uart_cfg_t        cfg_reg, cfg_next;
  logic [7:0]       data_reg, data_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic             stop_phase_reg, stop_phase_next;
  logic             tx_reg, tx_next;
  logic             busy_reg, done_reg, done_next;

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_data;
  logic [DIV_W-1:0] p_div, p_last;
  logic [2:0]       last_idx;
  logic [7:0]       data_mask;
  logic             parity_bit, bit_end;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push.tx_valid),
    .push_data (push.tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  assign push.tx_ready = !fifo_full;

  // A divisor of zero behaves like one: the bit ends on the first count.
  assign p_div    = DIV_W'(cfg_reg.clks_per_bit);
  assign p_last   = (p_div == '0) ? '0 : p_div - 1'b1;
  assign bit_end  = (cnt_reg == p_last);
  assign last_idx = last_bit_idx(cfg_reg.data_bits);

  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign data_mask[gi] = (3'(gi) <= last_idx);
  end

  assign parity_bit = (^(data_reg & data_mask)) ^ cfg_reg.parity_odd;

  always_comb begin
    state_next      = state_reg;
    cfg_next        = cfg_reg;
    data_next       = data_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    stop_phase_next = stop_phase_reg;
    fifo_pop        = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          fifo_pop              = 1'b1;
          data_next             = fifo_data;
          cfg_next.clks_per_bit = UART_DIV_W'(cfg_clks_per_bit_i);
          cfg_next.data_bits    = cfg_data_bits_i;
          cfg_next.parity_en    = cfg_parity_en_i;
          cfg_next.parity_odd   = cfg_parity_odd_i;
          cfg_next.stop2        = cfg_stop2_i;
          state_next            = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx_reg == last_idx) begin
            stop_phase_next = 1'b0;
            state_next      = cfg_reg.parity_en ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_next        = '0;
          stop_phase_next = 1'b0;
          state_next      = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (cfg_reg.stop2 && !stop_phase_reg) begin
            stop_phase_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is decoded from the next state so tx_o comes straight off a flop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_next[idx_next];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase

    done_next = (state_next == STOP) && (cnt_next == p_last) &&
                (!cfg_reg.stop2 || stop_phase_next);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      cfg_reg        <= '0;
      data_reg       <= '0;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      stop_phase_reg <= 1'b0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cfg_reg        <= cfg_next;
      data_reg       <= data_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      stop_phase_reg <= stop_phase_next;
      tx_reg         <= tx_next;
      busy_reg       <= (state_next != IDLE);
      done_reg       <= done_next;
    end
  end

  assign tx_o   = tx_reg;
  assign busy_o = busy_reg;
  assign done_o = done_reg;

endmodule
